// File: rtl/exe_stage_md_if.sv
// -----------------------------------------------------------------------------
// exe_stage_md_if
// Bus bundle between the ID stage, the multi-cycle EXE stage and the MEM stage.
//   ID -> EXE : id_to_exe_valid, in_md_op, in_src1, in_src2, in_alu_res,
//               in_dest, in_rf_we, in_pc, flush
//   EXE -> ID : exe_allow_in, exe_fwd_en, exe_hazard
//   EXE -> MEM: exe_to_mem_valid, out_result, out_dest, out_rf_we, out_pc
//   MEM -> EXE: mem_allow_in
// Modports: slave  = the EXE stage itself
//           master = the surrounding pipeline (ID/MEM side, or a testbench)
// -----------------------------------------------------------------------------
interface exe_stage_md_if #(
    parameter int DW = 32
);
    logic          flush;
    logic          id_to_exe_valid;
    logic          exe_allow_in;
    logic [2:0]    in_md_op;
    logic [DW-1:0] in_src1;
    logic [DW-1:0] in_src2;
    logic [DW-1:0] in_alu_res;
    logic [4:0]    in_dest;
    logic          in_rf_we;
    logic [31:0]   in_pc;
    logic          mem_allow_in;
    logic          exe_to_mem_valid;
    logic [DW-1:0] out_result;
    logic [4:0]    out_dest;
    logic          out_rf_we;
    logic [31:0]   out_pc;
    logic          exe_fwd_en;
    logic          exe_hazard;

    modport slave (
        input  flush, id_to_exe_valid, in_md_op, in_src1, in_src2, in_alu_res,
               in_dest, in_rf_we, in_pc, mem_allow_in,
        output exe_allow_in, exe_to_mem_valid, out_result, out_dest, out_rf_we,
               out_pc, exe_fwd_en, exe_hazard
    );

    modport master (
        output flush, id_to_exe_valid, in_md_op, in_src1, in_src2, in_alu_res,
               in_dest, in_rf_we, in_pc, mem_allow_in,
        input  exe_allow_in, exe_to_mem_valid, out_result, out_dest, out_rf_we,
               out_pc, exe_fwd_en, exe_hazard
    );
endinterface

// File: rtl/exe_stage_md.sv
// -----------------------------------------------------------------------------
// exe_stage_md
// EXE pipeline stage with an iterative multiply/divide unit and the
// architectural HI/LO registers.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : exe_stage_md_if.slave (ID handshake in, MEM handshake out,
//            bypass/stall exports to ID)
// Opcodes (in_md_op): 000 PASS, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//                     101 MFHI, 110 MFLO, 111 PASS.
// MD ops hold the stage (ready_go=0) until the FSM reaches DONE; HI/LO are
// written only when a finished MD op is handed to MEM, so a following
// MFHI/MFLO always reads committed values without forwarding.
// Build option: define FAST_MUL_EN to compute MULT/MULTU with a single-cycle
// combinational product (IDLE->DONE directly); DIV/DIVU stay iterative.
// -----------------------------------------------------------------------------
module exe_stage_md #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          resetn,
    exe_stage_md_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // Stage register
    logic            valid_r;
    logic [2:0]      op_r;
    logic [DW-1:0]   src1_r;
    logic [DW-1:0]   src2_r;
    logic [4:0]      dest_r;
    logic            rf_we_r;
    logic [31:0]     pc_r;
    logic [DW-1:0]   out_result_r;

    // MD engine state
    md_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2*DW-1:0] acc_r;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [DW-1:0]   opa_r;      // mul: multiplicand magnitude; div: divisor magnitude
    logic            neg_lo_r;   // negate product / quotient at the end
    logic            neg_hi_r;   // negate remainder at the end
    logic [DW-1:0]   md_hi_r;    // finished HI waiting for handoff (LO sits in out_result_r)

    // Architectural HI/LO
    logic [DW-1:0]   hi_r;
    logic [DW-1:0]   lo_r;

    // Combinational helpers
    logic            is_mul_s;
    logic            is_div_s;
    logic            is_signed_s;
    logic            is_md_s;
    logic            ready_go_s;
    logic            allow_in_s;
    logic            handoff_s;
    logic            md_commit_s;
    logic            latch_s;
    logic [DW-1:0]   hi_view_s;
    logic [DW-1:0]   lo_view_s;
    logic [DW-1:0]   abs1_s;
    logic [DW-1:0]   abs2_s;
    logic            div0_s;
    logic [DW:0]     mul_sum_s;
    logic [2*DW-1:0] mul_acc_s;
    logic [DW:0]     div_part_s;
    logic [DW:0]     div_diff_s;
    logic [2*DW-1:0] div_acc_s;
    logic [2*DW-1:0] step_acc_s;
    logic [2*DW-1:0] prod_s;
    logic [DW-1:0]   quo_s;
    logic [DW-1:0]   rem_s;
    logic [DW-1:0]   fin_hi_s;
    logic [DW-1:0]   fin_lo_s;
    logic            last_iter_s;
    logic            done_set_s;
    logic            start_calc_s;
    logic [DW-1:0]   done_hi_s;
    logic [DW-1:0]   done_lo_s;

`ifdef FAST_MUL_EN
    logic [2*DW-1:0] fast_a_s;
    logic [2*DW-1:0] fast_b_s;
    logic [2*DW-1:0] fast_prod_s;
`endif

    // Classify the latched opcode.
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (op_r)
            OP_MULT: begin
                is_mul_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_MULTU: is_mul_s = 1'b1;
            OP_DIV: begin
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_DIVU: is_div_s = 1'b1;
            default: is_mul_s = 1'b0;
        endcase
        is_md_s = is_mul_s | is_div_s;
    end

    // ready_go: non-MD ops finish immediately, MD ops only once the engine is in DONE.
    always_comb begin
        if (is_md_s) begin
            ready_go_s = (state_r == ST_DONE);
        end else begin
            ready_go_s = 1'b1;
        end
    end

    assign allow_in_s  = ~valid_r | (ready_go_s & bus.mem_allow_in);
    assign handoff_s   = valid_r & ready_go_s & bus.mem_allow_in & ~bus.flush;
    assign md_commit_s = handoff_s & is_md_s;
    assign latch_s     = bus.id_to_exe_valid & allow_in_s & ~bus.flush;

    // An MFHI/MFLO latched on the very edge an MD op commits must see the new value.
    always_comb begin
        if (md_commit_s) begin
            hi_view_s = md_hi_r;
            lo_view_s = out_result_r;
        end else begin
            hi_view_s = hi_r;
            lo_view_s = lo_r;
        end
    end

    // Operand magnitudes; signed ops work on absolute values and fix signs at the end.
    always_comb begin
        if (is_signed_s && src1_r[DW-1]) begin
            abs1_s = -src1_r;
        end else begin
            abs1_s = src1_r;
        end
        if (is_signed_s && src2_r[DW-1]) begin
            abs2_s = -src2_r;
        end else begin
            abs2_s = src2_r;
        end
        div0_s = is_div_s & (src2_r == {DW{1'b0}});
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*DW-1:DW]} + {1'b0, (acc_r[0] ? opa_r : {DW{1'b0}})};
        mul_acc_s  = {mul_sum_s, acc_r[DW-1:1]};
        // Partial remainder after shifting in the next dividend bit needs DW+1 bits.
        div_part_s = acc_r[2*DW-1:DW-1];
        div_diff_s = div_part_s - {1'b0, opa_r};
        if (div_diff_s[DW] == 1'b0) begin
            div_acc_s = {div_diff_s[DW-1:0], acc_r[DW-2:0], 1'b1};
        end else begin
            div_acc_s = {div_part_s[DW-1:0], acc_r[DW-2:0], 1'b0};
        end
        if (is_div_s) begin
            step_acc_s = div_acc_s;
        end else begin
            step_acc_s = mul_acc_s;
        end
    end

    // Sign correction applied to the result of the final iteration.
    always_comb begin
        quo_s = step_acc_s[DW-1:0];
        rem_s = step_acc_s[2*DW-1:DW];
        if (neg_lo_r) begin
            prod_s = -step_acc_s;
        end else begin
            prod_s = step_acc_s;
        end
        if (is_div_s) begin
            if (neg_lo_r) begin
                fin_lo_s = -quo_s;
            end else begin
                fin_lo_s = quo_s;
            end
            if (neg_hi_r) begin
                fin_hi_s = -rem_s;
            end else begin
                fin_hi_s = rem_s;
            end
        end else begin
            fin_lo_s = prod_s[DW-1:0];
            fin_hi_s = prod_s[2*DW-1:DW];
        end
    end

`ifdef FAST_MUL_EN
    // Single-cycle product: extend to 2DW so the truncated product is exact for both signednesses.
    always_comb begin
        if (is_signed_s) begin
            fast_a_s = {{DW{src1_r[DW-1]}}, src1_r};
            fast_b_s = {{DW{src2_r[DW-1]}}, src2_r};
        end else begin
            fast_a_s = {{DW{1'b0}}, src1_r};
            fast_b_s = {{DW{1'b0}}, src2_r};
        end
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    assign last_iter_s = (state_r == ST_CALC) && (cnt_r == CNT_W'(DW - 1));

    // Decide whether the engine starts iterating or enters DONE on this edge.
    always_comb begin
        done_set_s   = 1'b0;
        start_calc_s = 1'b0;
        done_hi_s    = {DW{1'b0}};
        done_lo_s    = {DW{1'b0}};
        if (bus.flush) begin
            done_set_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_r && is_md_s) begin
                        if (div0_s) begin
                            done_set_s = 1'b1;
                            done_hi_s  = src1_r;
                            done_lo_s  = {DW{1'b1}};
`ifdef FAST_MUL_EN
                        end else if (is_mul_s) begin
                            done_set_s = 1'b1;
                            done_hi_s  = fast_prod_s[2*DW-1:DW];
                            done_lo_s  = fast_prod_s[DW-1:0];
`endif
                        end else begin
                            start_calc_s = 1'b1;
                        end
                    end else begin
                        start_calc_s = 1'b0;
                    end
                end
                ST_CALC: begin
                    if (last_iter_s) begin
                        done_set_s = 1'b1;
                        done_hi_s  = fin_hi_s;
                        done_lo_s  = fin_lo_s;
                    end else begin
                        done_set_s = 1'b0;
                    end
                end
                default: done_set_s = 1'b0;
            endcase
        end
    end

    // MD engine FSM: IDLE -> CALC (DW iterations) -> DONE -> IDLE on handoff.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*DW){1'b0}};
            opa_r    <= {DW{1'b0}};
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            md_hi_r  <= {DW{1'b0}};
        end else if (bus.flush) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (done_set_s) begin
                        state_r <= ST_DONE;
                        md_hi_r <= done_hi_s;
                    end else if (start_calc_s) begin
                        state_r  <= ST_CALC;
                        cnt_r    <= {CNT_W{1'b0}};
                        opa_r    <= is_div_s ? abs2_s : abs1_s;
                        acc_r    <= {{DW{1'b0}}, (is_div_s ? abs1_s : abs2_s)};
                        neg_lo_r <= is_signed_s & (src1_r[DW-1] ^ src2_r[DW-1]);
                        neg_hi_r <= is_signed_s & is_div_s & src1_r[DW-1];
                    end
                end
                ST_CALC: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (done_set_s) begin
                        state_r <= ST_DONE;
                        md_hi_r <= done_hi_s;
                    end
                end
                ST_DONE: begin
                    if (bus.mem_allow_in) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Stage register, valid bit and the registered write-back value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_r      <= 1'b0;
            op_r         <= 3'b000;
            src1_r       <= {DW{1'b0}};
            src2_r       <= {DW{1'b0}};
            dest_r       <= 5'd0;
            rf_we_r      <= 1'b0;
            pc_r         <= 32'd0;
            out_result_r <= {DW{1'b0}};
        end else begin
            if (bus.flush) begin
                valid_r <= 1'b0;
            end else if (allow_in_s) begin
                valid_r <= bus.id_to_exe_valid;
            end
            if (latch_s) begin
                op_r    <= bus.in_md_op;
                src1_r  <= bus.in_src1;
                src2_r  <= bus.in_src2;
                dest_r  <= bus.in_dest;
                rf_we_r <= bus.in_rf_we;
                pc_r    <= bus.in_pc;
                case (bus.in_md_op)
                    OP_MFHI:  out_result_r <= hi_view_s;
                    OP_MFLO:  out_result_r <= lo_view_s;
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: out_result_r <= {DW{1'b0}};
                    default:  out_result_r <= bus.in_alu_res;
                endcase
            end else if (done_set_s) begin
                out_result_r <= done_lo_s;
            end
        end
    end

    // HI/LO change only when a finished MD op leaves for MEM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_r <= {DW{1'b0}};
            lo_r <= {DW{1'b0}};
        end else if (md_commit_s) begin
            hi_r <= md_hi_r;
            lo_r <= out_result_r;
        end
    end

    assign bus.exe_allow_in     = allow_in_s;
    assign bus.exe_to_mem_valid = valid_r & ready_go_s;
    assign bus.out_result       = out_result_r;
    assign bus.out_dest         = dest_r;
    assign bus.out_rf_we        = rf_we_r;
    assign bus.out_pc           = pc_r;
    assign bus.exe_fwd_en       = valid_r & rf_we_r & ready_go_s;
    assign bus.exe_hazard       = valid_r & rf_we_r & ~ready_go_s;

endmodule
